vc_qspi_mem_responder: RTL and testbench
========================================

// Module: vc_qspi_mem_responder
// PURPOSE
//  Memory-side end of the CPU's quad-SPI external memory interface: emulates a PSRAM
//  answering quad read (0xEB) and quad write (0x38) transactions from the vc CPU pins.
//  Used in the FPGA companion/testboard image and in system sims. It is the target
//  side of the link the CPU drives.
//  qspi_sck/cs_n/io are oversampled in the clk domain, so clk must be >= 4x sck.
// PARAMETERS
//  AW      12  byte-address bits of internal memory (2^AW bytes); upper addr bits ignored
//  DUMMY   6   sck cycles between last address nibble and first read data nibble
//  SYNC    2   synchronizer flop stages on cs_n/sck/io_in
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  qspi_cs_n    in   1   chip select, active low
//  qspi_sck     in   1   serial clock from CPU (sampled, not used as a clock)
//  qspi_io_in   in   4   quad data from CPU
//  qspi_io_out  out  4   quad data to CPU
//  qspi_io_oe   out  4   output enable, 4'hF while driving read data
//  ld_we        in   1   backdoor preload strobe
//  ld_addr      in   AW  backdoor address
//  ld_data      in   8   backdoor data
//  busy         out  1   high while a transaction is in progress (state != IDLE)
//  cmd_err      out  1   one-clk pulse when an unsupported command byte completes
// BEHAVIOUR
//  Reset: qspi_io_out=0, qspi_io_oe=0, busy=0, cmd_err=0, state IDLE. Memory not reset.
//  Sampling: inputs captured on synchronized sck rising edge; outputs change on the
//   synchronized sck falling edge. cs_n rise in any state -> IDLE next clk, oe=0 same clk.
//  Nibble order: high nibble first for command, address (MSB first) and data.
//  FSM:
//   IDLE   cs_n fall -> CMD, nibble count 0.
//   CMD    2 rising edges build cmd; 0xEB -> ADDR(read); 0x38 -> ADDR(write);
//          other -> pulse cmd_err, IGNORE.
//   ADDR   6 rising edges build 24-bit addr; read -> DUMMY, write -> WDATA.
//   DUMMY  DUMMY rising edges; byte at addr fetched; on falling edge after last dummy
//          rising edge -> RDATA, oe=4'hF, high nibble driven.
//   RDATA  each falling edge drives next nibble; after low nibble, addr+1 mod 2^AW
//          and next byte is presented on the following falling edge (no gap).
//   WDATA  rising edges collect nibble pairs; byte written on 2nd nibble; addr+1
//          mod 2^AW. Partial byte at cs_n rise is discarded.
//   IGNORE wait for cs_n rise; io never driven.
//  Boundaries: addr 2^AW-1 wraps to 0 in both directions; DUMMY=0 -> RDATA entered on the
//   falling edge after last address nibble; cs_n rise during CMD/ADDR/DUMMY -> no memory
//   effect; ld_we and QSPI write to same byte in the same clk -> ld_data wins; ld_we
//   to the byte being read lands only if before that byte's fetch.
// CONFIGURATION
//  VC_QSPI_RESP_WRITE_EN defined: 0x38 supported as above.
//  Not defined: write path and WDATA state removed; 0x38 treated as unsupported
//   (cmd_err pulse, IGNORE); memory writable only via ld_* port.
// STRUCTURE
//  Package vc_qspi_pkg: state enum (IDLE,CMD,ADDR,DUMMY,RDATA,WDATA,IGNORE),
//   CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, ADDR_NIBBLES=6.
//  Sub-module vc_qspi_sync_edge: SYNC-stage synchronizer for cs_n/sck/io_in producing
//   sck_rise, sck_fall, cs_fall, cs_rise pulses; instantiated once.
// TESTING
//  Preload 0x010..0x013 = 11,22,33,44; 0xEB addr 0x000010, 6 dummy, 8 data nibbles
//   -> io_out 1,1,2,2,3,3,4,4; oe=F from first data falling edge, 0 after cs_n rise.
//  0x38 addr 0x000FFF data A5,5A then 0xEB addr 0xFFF -> reads A5 then 5A (wrap to 0x000).
//  Command 0x9F -> cmd_err one clk, oe stays 0, busy until cs_n rise; next 0xEB works.
//  0x38 addr 0x20, 3 data nibbles (B,C,D), cs_n rise -> 0x20=BC, 0x21 unchanged.
//  rst_n low mid-RDATA -> oe=0, io_out=0, busy=0 immediately; memory contents retained.
//  Build without VC_QSPI_RESP_WRITE_EN: 0x38 -> cmd_err pulse, target byte unchanged.

Source files
------------

// File: rtl/vc_qspi_pkg.sv
// Shared types and constants for the quad-SPI PSRAM responder.
// No logic; no latency.
// No flow control.
package vc_qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/vc_qspi_sync_edge.sv
// Synchronizes cs_n/sck/io into clk and produces single-clk edge pulses.
// Latency: SYNC clk to the synchronized level, pulses decoded combinationally from it.
// No backpressure; every input edge yields exactly one pulse.
module vc_qspi_sync_edge #(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sck,
    input  logic [3:0] io_in,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic [3:0] io_s
);

    // One extra stage beyond SYNC holds the previous synchronized level.
    logic [SYNC:0] cs_sh;
    logic [SYNC:0] sck_sh;
    logic [3:0]    io_sh [SYNC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sh  <= '1;
            sck_sh <= '0;
            for (int i = 0; i < SYNC; i++) io_sh[i] <= '0;
        end else begin
            cs_sh    <= {cs_sh[SYNC-1:0], cs_n};
            sck_sh   <= {sck_sh[SYNC-1:0], sck};
            io_sh[0] <= io_in;
            for (int i = 1; i < SYNC; i++) io_sh[i] <= io_sh[i-1];
        end
    end

    assign cs_fall  = !cs_sh[SYNC-1] &&  cs_sh[SYNC];
    assign cs_rise  =  cs_sh[SYNC-1] && !cs_sh[SYNC];
    assign sck_rise =  sck_sh[SYNC-1] && !sck_sh[SYNC];
    assign sck_fall = !sck_sh[SYNC-1] &&  sck_sh[SYNC];
    assign io_s     = io_sh[SYNC-1];

endmodule

// File: rtl/vc_qspi_mem_responder.sv
// PSRAM emulator answering quad read 0xEB and, with VC_QSPI_RESP_WRITE_EN, quad write 0x38.
// Latency: SYNC+1 clk from a pin edge to the FSM reacting; read data follows DUMMY sck cycles.
// No backpressure: the CPU owns sck, clk must run at least 4x sck.
module vc_qspi_mem_responder
    import vc_qspi_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DUMMY = 6,
    parameter int SYNC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          qspi_cs_n,
    input  logic          qspi_sck,
    input  logic [3:0]    qspi_io_in,
    output logic [3:0]    qspi_io_out,
    output logic [3:0]    qspi_io_oe,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          busy,
    output logic          cmd_err
);

    localparam logic [7:0]    DUMMY_CNT = 8'(DUMMY);
    localparam logic [7:0]    ADDR_LAST = 8'(ADDR_NIBBLES - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    logic       cs_fall, cs_rise, sck_rise, sck_fall;
    logic [3:0] io_s;

    vc_qspi_sync_edge #(.SYNC(SYNC)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (qspi_cs_n),
        .sck      (qspi_sck),
        .io_in    (qspi_io_in),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .io_s     (io_s)
    );

    state_t        state;
    logic [7:0]    cnt;
    logic [3:0]    cmd_hi;
    logic [AW-1:0] addr;
    logic [3:0]    rd_lo;
    logic          rd_phase;
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    cmd_full;
    logic [7:0]    rd_byte;

    assign cmd_full = {cmd_hi, io_s};
    assign rd_byte  = mem[addr];
    assign busy     = (state != ST_IDLE);

`ifdef VC_QSPI_RESP_WRITE_EN
    logic       is_wr;
    logic       wr_phase;
    logic [3:0] wr_nib;
    logic       q_we;

    assign q_we = (state == ST_WDATA) && sck_rise && wr_phase;
`endif

    // Backdoor write is issued last so it overrides a same-clk QSPI write to the same byte.
    always_ff @(posedge clk) begin
`ifdef VC_QSPI_RESP_WRITE_EN
        if (q_we) mem[addr] <= {wr_nib, io_s};
`endif
        if (ld_we) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cmd_hi      <= '0;
            addr        <= '0;
            rd_lo       <= '0;
            rd_phase    <= 1'b0;
            qspi_io_out <= '0;
            qspi_io_oe  <= '0;
            cmd_err     <= 1'b0;
`ifdef VC_QSPI_RESP_WRITE_EN
            is_wr       <= 1'b0;
            wr_phase    <= 1'b0;
            wr_nib      <= '0;
`endif
        end else begin
            cmd_err <= 1'b0;
            if (cs_rise) begin
                state       <= ST_IDLE;
                qspi_io_oe  <= '0;
                qspi_io_out <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (cs_fall) begin
                        state <= ST_CMD;
                        cnt   <= '0;
                    end
                    ST_CMD: if (sck_rise) begin
                        cmd_hi <= io_s;
                        cnt    <= cnt + 8'd1;
                        if (cnt == 8'd1) begin
                            cnt <= '0;
                            if (cmd_full == CMD_QREAD) begin
                                state <= ST_ADDR;
`ifdef VC_QSPI_RESP_WRITE_EN
                                is_wr <= 1'b0;
                            end else if (cmd_full == CMD_QWRITE) begin
                                state <= ST_ADDR;
                                is_wr <= 1'b1;
`endif
                            end else begin
                                state   <= ST_IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    // Only the low AW address bits survive the shift.
                    ST_ADDR: if (sck_rise) begin
                        addr <= AW'({addr, io_s});
                        cnt  <= cnt + 8'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt   <= '0;
                            state <= ST_DUMMY;
`ifdef VC_QSPI_RESP_WRITE_EN
                            if (is_wr) state <= ST_WDATA;
                            wr_phase <= 1'b0;
`endif
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise && cnt != DUMMY_CNT) cnt <= cnt + 8'd1;
                        if (sck_fall && cnt == DUMMY_CNT) begin
                            state       <= ST_RDATA;
                            qspi_io_oe  <= 4'hF;
                            qspi_io_out <= rd_byte[7:4];
                            rd_lo       <= rd_byte[3:0];
                            rd_phase    <= 1'b1;
                        end
                    end
                    // Byte is fetched when its high nibble goes out; low nibble comes from rd_lo.
                    ST_RDATA: if (sck_fall) begin
                        if (rd_phase) begin
                            qspi_io_out <= rd_lo;
                            addr        <= addr + ADDR_ONE;
                            rd_phase    <= 1'b0;
                        end else begin
                            qspi_io_out <= rd_byte[7:4];
                            rd_lo       <= rd_byte[3:0];
                            rd_phase    <= 1'b1;
                        end
                    end
`ifdef VC_QSPI_RESP_WRITE_EN
                    ST_WDATA: if (sck_rise) begin
                        if (!wr_phase) begin
                            wr_nib   <= io_s;
                            wr_phase <= 1'b1;
                        end else begin
                            wr_phase <= 1'b0;
                            addr     <= addr + ADDR_ONE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vc_qspi_mem_responder.sv
// Directed bench for vc_qspi_mem_responder acting as the CPU side of the quad-SPI link.
module tb_vc_qspi_mem_responder;

    localparam int AW      = 12;
    localparam int DUMMY_T = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          qspi_cs_n = 1'b1;
    logic          qspi_sck = 1'b0;
    logic [3:0]    qspi_io_in = 4'h0;
    logic [3:0]    qspi_io_out;
    logic [3:0]    qspi_io_oe;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          busy;
    logic          cmd_err;

    int passed = 0;
    int total  = 0;
    int err_cnt = 0;
    logic [3:0] rd_nib [0:15];
    logic [3:0] rd_oe;

    vc_qspi_mem_responder #(.AW(AW), .DUMMY(DUMMY_T), .SYNC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .qspi_cs_n   (qspi_cs_n),
        .qspi_sck    (qspi_sck),
        .qspi_io_in  (qspi_io_in),
        .qspi_io_out (qspi_io_out),
        .qspi_io_oe  (qspi_io_oe),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // One full sck period: rise, hold 4 clk, fall, hold 4 clk.
    task automatic clk_sck(input logic [3:0] d);
        qspi_io_in = d;
        @(negedge clk);
        qspi_sck = 1'b1;
        repeat (4) @(negedge clk);
        qspi_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic qspi_start(input logic [7:0] c, input logic [23:0] a);
        qspi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        clk_sck(c[7:4]);
        clk_sck(c[3:0]);
        for (int i = 0; i < 6; i++) clk_sck(a[23-4*i -: 4]);
    endtask

    task automatic qspi_end();
        qspi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic qspi_read(input logic [23:0] a, input int n, input bit keep_open);
        qspi_start(8'hEB, a);
        for (int i = 0; i < DUMMY_T; i++) clk_sck(4'h0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) clk_sck(4'h0);
            rd_nib[i] = qspi_io_out;
            if (i == 0) rd_oe = qspi_io_oe;
        end
        if (!keep_open) qspi_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (qspi_io_out !== 4'h0) $display("FAIL reset io_out got %h exp 0", qspi_io_out); else passed++;
        total++; if (qspi_io_oe !== 4'h0) $display("FAIL reset io_oe got %h exp 0", qspi_io_oe); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else passed++;
        total++; if (cmd_err !== 1'b0) $display("FAIL reset cmd_err got %b exp 0", cmd_err); else passed++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL post-reset busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_read();
        logic [31:0] exp;
        exp = 32'h11223344;
        preload(12'h010, 8'h11);
        preload(12'h011, 8'h22);
        preload(12'h012, 8'h33);
        preload(12'h013, 8'h44);
        qspi_read(24'h000010, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++; if (rd_nib[i] !== exp[31-4*i -: 4]) $display("FAIL read nib%0d got %h exp %h", i, rd_nib[i], exp[31-4*i -: 4]); else passed++;
        end
        total++; if (rd_oe !== 4'hF) $display("FAIL read oe first nibble got %h exp f", rd_oe); else passed++;
        total++; if (qspi_io_oe !== 4'h0) $display("FAIL read oe after cs rise got %h exp 0", qspi_io_oe); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL read busy after cs rise got %b exp 0", busy); else passed++;
    endtask

    task automatic test_bad_cmd();
        int e0;
        e0 = err_cnt;
        qspi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        clk_sck(4'h9);
        clk_sck(4'hF);
        total++; if (err_cnt !== e0 + 1) $display("FAIL badcmd err pulses got %0d exp %0d", err_cnt - e0, 1); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL badcmd busy got %b exp 1", busy); else passed++;
        for (int i = 0; i < 8; i++) clk_sck(4'h0);
        total++; if (qspi_io_oe !== 4'h0) $display("FAIL badcmd oe got %h exp 0", qspi_io_oe); else passed++;
        total++; if (err_cnt !== e0 + 1) $display("FAIL badcmd err width got %0d exp %0d", err_cnt - e0, 1); else passed++;
        qspi_end();
        total++; if (busy !== 1'b0) $display("FAIL badcmd busy after cs got %b exp 0", busy); else passed++;
        qspi_read(24'h000010, 2, 1'b0);
        total++; if (rd_nib[0] !== 4'h1) $display("FAIL badcmd next read nib0 got %h exp 1", rd_nib[0]); else passed++;
        total++; if (rd_nib[1] !== 4'h1) $display("FAIL badcmd next read nib1 got %h exp 1", rd_nib[1]); else passed++;
    endtask

    task automatic test_wrap_read();
        logic [15:0] exp;
        exp = 16'hC33C;
        preload(12'hFFF, 8'hC3);
        preload(12'h000, 8'h3C);
        qspi_read(24'h123FFF, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_nib[i] !== exp[15-4*i -: 4]) $display("FAIL wrapread nib%0d got %h exp %h", i, rd_nib[i], exp[15-4*i -: 4]); else passed++;
        end
    endtask

`ifdef VC_QSPI_RESP_WRITE_EN
    task automatic test_write_wrap();
        logic [15:0] exp;
        int e0;
        exp = 16'hA55A;
        e0 = err_cnt;
        qspi_start(8'h38, 24'h000FFF);
        for (int i = 0; i < 4; i++) clk_sck(exp[15-4*i -: 4]);
        qspi_end();
        total++; if (err_cnt !== e0) $display("FAIL write cmd_err got %0d exp 0", err_cnt - e0); else passed++;
        qspi_read(24'h000FFF, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_nib[i] !== exp[15-4*i -: 4]) $display("FAIL writewrap nib%0d got %h exp %h", i, rd_nib[i], exp[15-4*i -: 4]); else passed++;
        end
    endtask

    task automatic test_partial_write();
        logic [15:0] exp;
        exp = 16'hBC77;
        preload(12'h020, 8'h00);
        preload(12'h021, 8'h77);
        qspi_start(8'h38, 24'h000020);
        clk_sck(4'hB);
        clk_sck(4'hC);
        clk_sck(4'hD);
        qspi_end();
        qspi_read(24'h000020, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_nib[i] !== exp[15-4*i -: 4]) $display("FAIL partial nib%0d got %h exp %h", i, rd_nib[i], exp[15-4*i -: 4]); else passed++;
        end
    endtask
`else
    task automatic test_write_disabled();
        int e0;
        preload(12'h030, 8'h66);
        e0 = err_cnt;
        qspi_start(8'h38, 24'h000030);
        clk_sck(4'h1);
        clk_sck(4'h1);
        total++; if (qspi_io_oe !== 4'h0) $display("FAIL wrdis oe got %h exp 0", qspi_io_oe); else passed++;
        qspi_end();
        total++; if (err_cnt !== e0 + 1) $display("FAIL wrdis err pulses got %0d exp %0d", err_cnt - e0, 1); else passed++;
        qspi_read(24'h000030, 2, 1'b0);
        total++; if (rd_nib[0] !== 4'h6) $display("FAIL wrdis nib0 got %h exp 6", rd_nib[0]); else passed++;
        total++; if (rd_nib[1] !== 4'h6) $display("FAIL wrdis nib1 got %h exp 6", rd_nib[1]); else passed++;
    endtask
`endif

    task automatic test_reset_mid_read();
        logic [15:0] exp;
        exp = 16'h1122;
        qspi_read(24'h000010, 2, 1'b1);
        total++; if (qspi_io_oe !== 4'hF) $display("FAIL midrst oe before got %h exp f", qspi_io_oe); else passed++;
        rst_n = 1'b0;
        qspi_cs_n = 1'b1;
        #1;
        total++; if (qspi_io_oe !== 4'h0) $display("FAIL midrst oe got %h exp 0", qspi_io_oe); else passed++;
        total++; if (qspi_io_out !== 4'h0) $display("FAIL midrst io_out got %h exp 0", qspi_io_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst busy got %b exp 0", busy); else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        qspi_read(24'h000010, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_nib[i] !== exp[15-4*i -: 4]) $display("FAIL midrst retained nib%0d got %h exp %h", i, rd_nib[i], exp[15-4*i -: 4]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_bad_cmd();
        test_wrap_read();
`ifdef VC_QSPI_RESP_WRITE_EN
        test_write_wrap();
        test_partial_write();
`else
        test_write_disabled();
`endif
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
